// File: rtl/mem_bridge.sv
`timescale 1ns/1ps
`default_nettype none
//------------------------------------------------------------------------------
// Module   : mem_bridge
// Purpose  : Byte-addressed request port to a word SRAM, with unaligned split/merge and debug register
// Revision : 1.0
//------------------------------------------------------------------------------
module mem_bridge #(
   parameter int          RAM_AW     = 10,
   parameter logic [31:0] DEBUG_ADDR = 32'hFFFF_FFF0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [31:0]       req_addr,
   input  logic [31:0]       req_wdata,
   output logic              resp_valid,
   output logic [31:0]       resp_rdata,
   output logic [RAM_AW-1:0] ram_addr,
   output logic              ram_re,
   output logic              ram_we,
   output logic [3:0]        ram_be,
   output logic [31:0]       ram_wdata,
   input  logic [31:0]       ram_rdata,
   output logic [7:0]        debug_out
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      ACCESS0 = 3'd1,
      ACCESS1 = 3'd2,
      COLLECT = 3'd3,
      RESPOND = 3'd4
   } state_t;

   state_t            r_state;
   state_t            w_state_nx;

   // Latched request fields
   logic              r_write;
   logic              r_dbg;
   logic [1:0]        r_off;
   logic [RAM_AW-1:0] r_word;
   logic [31:0]       r_wdata;
   logic [31:8]       r_lo;

   // Registered outputs
   logic              r_req_ready;
   logic              r_resp_valid;
   logic [31:0]       r_resp_rdata;
   logic [RAM_AW-1:0] r_ram_addr;
   logic              r_ram_re;
   logic              r_ram_we;
   logic [3:0]        r_ram_be;
   logic [31:0]       r_ram_wdata;
   logic [7:0]        r_debug;

   // Next-state values
   logic              w_accept;
   logic              w_req_dbg;
   logic [1:0]        w_req_off;
   logic [RAM_AW-1:0] w_req_word;
   logic [3:0]        w_be_lo;
   logic [3:0]        w_be_hi;
   logic [31:0]       w_wdata_lo;
   logic [31:0]       w_wdata_hi;
   logic [31:0]       w_merge;
   logic              w_ready_nx;
   logic              w_rv_nx;
   logic [31:0]       w_rdata_nx;
   logic [RAM_AW-1:0] w_raddr_nx;
   logic              w_re_nx;
   logic              w_we_nx;
   logic [3:0]        w_be_nx;
   logic [31:0]       w_wdata_nx;
   logic [7:0]        w_debug_nx;
   logic [31:8]       w_lo_nx;

   assign w_accept   = req_valid && r_req_ready;
   assign w_req_dbg  = (req_addr == DEBUG_ADDR);
   assign w_req_off  = req_addr[1:0];
   assign w_req_word = req_addr[RAM_AW+1:2];

   // First word takes the low lanes shifted up; second word takes the spill-over lanes.
   assign w_be_lo    = 4'b1111 << w_req_off;
   assign w_wdata_lo = req_wdata << {w_req_off, 3'b000};
   assign w_be_hi    = 4'b1111 >> (3'd4 - {1'b0, r_off});
   assign w_wdata_hi = r_wdata >> (6'd32 - {1'b0, r_off, 3'b000});

   always_comb begin
      w_merge = ram_rdata;
      case (r_off)
         2'd1:    w_merge = {ram_rdata[7:0],  r_lo[31:8]};
         2'd2:    w_merge = {ram_rdata[15:0], r_lo[31:16]};
         2'd3:    w_merge = {ram_rdata[23:0], r_lo[31:24]};
         default: w_merge = ram_rdata;
      endcase
   end

   always_comb begin
      w_state_nx = r_state;
      w_ready_nx = 1'b0;
      w_rv_nx    = 1'b0;
      w_rdata_nx = r_resp_rdata;
      w_raddr_nx = r_ram_addr;
      w_re_nx    = 1'b0;
      w_we_nx    = 1'b0;
      w_be_nx    = 4'b0000;
      w_wdata_nx = r_ram_wdata;
      w_debug_nx = r_debug;
      w_lo_nx    = r_lo;

      case (r_state)
         IDLE, RESPOND: begin
            if (w_accept) begin
               w_state_nx = ACCESS0;
               if (!w_req_dbg) begin
                  w_raddr_nx = w_req_word;
                  if (req_write) begin
                     w_we_nx    = 1'b1;
                     w_be_nx    = w_be_lo;
                     w_wdata_nx = w_wdata_lo;
                  end else begin
                     w_re_nx    = 1'b1;
                  end
               end
            end else begin
               w_state_nx = IDLE;
            end
         end
         ACCESS0: begin
            if (r_dbg) begin
               w_state_nx = RESPOND;
               if (r_write) w_debug_nx = r_wdata[7:0];
               else         w_rdata_nx = {24'b0, r_debug};
            end else if (r_off == 2'd0) begin
               w_state_nx = r_write ? RESPOND : COLLECT;
            end else begin
               w_state_nx = ACCESS1;
               w_raddr_nx = r_word + 1'b1;
               if (r_write) begin
                  w_we_nx    = 1'b1;
                  w_be_nx    = w_be_hi;
                  w_wdata_nx = w_wdata_hi;
               end else begin
                  w_re_nx    = 1'b1;
               end
            end
         end
         ACCESS1: begin
            w_state_nx = r_write ? RESPOND : COLLECT;
            if (!r_write) w_lo_nx = ram_rdata[31:8];
         end
         COLLECT: begin
            w_state_nx = RESPOND;
            w_rdata_nx = w_merge;
         end
         default: w_state_nx = IDLE;
      endcase

      w_ready_nx = (w_state_nx == IDLE) || (w_state_nx == RESPOND);
      w_rv_nx    = (w_state_nx == RESPOND);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state      <= IDLE;
         r_write      <= 1'b0;
         r_dbg        <= 1'b0;
         r_off        <= 2'd0;
         r_word       <= '0;
         r_wdata      <= 32'd0;
         r_lo         <= 24'd0;
         r_req_ready  <= 1'b1;
         r_resp_valid <= 1'b0;
         r_resp_rdata <= 32'd0;
         r_ram_addr   <= '0;
         r_ram_re     <= 1'b0;
         r_ram_we     <= 1'b0;
         r_ram_be     <= 4'b0000;
         r_ram_wdata  <= 32'd0;
         r_debug      <= 8'hFF;
      end else begin
         r_state      <= w_state_nx;
         r_lo         <= w_lo_nx;
         r_req_ready  <= w_ready_nx;
         r_resp_valid <= w_rv_nx;
         r_resp_rdata <= w_rdata_nx;
         r_ram_addr   <= w_raddr_nx;
         r_ram_re     <= w_re_nx;
         r_ram_we     <= w_we_nx;
         r_ram_be     <= w_be_nx;
         r_ram_wdata  <= w_wdata_nx;
         r_debug      <= w_debug_nx;
         if (w_accept) begin
            r_write <= req_write;
            r_dbg   <= w_req_dbg;
            r_off   <= w_req_off;
            r_word  <= w_req_word;
            r_wdata <= req_wdata;
         end
      end
   end

   assign req_ready  = r_req_ready;
   assign resp_valid = r_resp_valid;
   assign resp_rdata = r_resp_rdata;
   assign ram_addr   = r_ram_addr;
   assign ram_re     = r_ram_re;
   assign ram_we     = r_ram_we;
   assign ram_be     = r_ram_be;
   assign ram_wdata  = r_ram_wdata;
   assign debug_out  = r_debug;

endmodule
`default_nettype wire

// File: tb/tb_mem_bridge.sv
`timescale 1ns/1ps
`default_nettype none
//------------------------------------------------------------------------------
// Module   : tb_mem_bridge
// Purpose  : Directed vector bench for mem_bridge with a behavioural word SRAM
// Revision : 1.0
//------------------------------------------------------------------------------
module tb_mem_bridge;
   localparam int          RAM_AW = 10;
   localparam logic [31:0] DBG    = 32'hFFFF_FFF0;

   logic              clk = 1'b0;
   logic              rst;
   logic              req_valid, req_ready, req_write;
   logic [31:0]       req_addr, req_wdata;
   logic              resp_valid;
   logic [31:0]       resp_rdata;
   logic [RAM_AW-1:0] ram_addr;
   logic              ram_re, ram_we;
   logic [3:0]        ram_be;
   logic [31:0]       ram_wdata, ram_rdata;
   logic [7:0]        debug_out;

   mem_bridge #(.RAM_AW(RAM_AW), .DEBUG_ADDR(DBG)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata),
      .ram_addr(ram_addr), .ram_re(ram_re), .ram_we(ram_we), .ram_be(ram_be),
      .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .debug_out(debug_out)
   );

   always #5 clk = ~clk;

   // Behavioural SRAM with a bench-side preload port
   logic [31:0]       mem [0:(1<<RAM_AW)-1];
   logic              pl_en;
   logic [RAM_AW-1:0] pl_addr;
   logic [31:0]       pl_data;

   always @(posedge clk) begin
      if (pl_en) mem[pl_addr] <= pl_data;
      if (ram_we)
         for (int i = 0; i < 4; i++)
            if (ram_be[i]) mem[ram_addr][8*i +: 8] <= ram_wdata[8*i +: 8];
      if (ram_re) ram_rdata <= mem[ram_addr];
   end

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic preload(input logic [RAM_AW-1:0] a, input logic [31:0] d);
      @(negedge clk);
      pl_en = 1'b1; pl_addr = a; pl_data = d;
      @(negedge clk);
      pl_en = 1'b0;
   endtask

   // Results of the most recent run()
   int                t_lat, t_nre, t_nwe;
   logic [31:0]       t_rd;
   logic [RAM_AW-1:0] t_last;
   logic [3:0]        t_be [2];

   task automatic run(input logic b2b, input logic wr, input logic [31:0] a, input logic [31:0] d);
      if (!b2b) @(negedge clk);
      chk("req_ready_before_issue", {31'b0, req_ready}, 32'd1);
      req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = d;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      t_lat = -1; t_nre = 0; t_nwe = 0; t_rd = 32'hx; t_last = '0;
      t_be[0] = 4'hx; t_be[1] = 4'hx;
      for (int k = 1; k <= 12; k++) begin
         if (ram_re) t_nre++;
         if (ram_we) begin
            if (t_nwe < 2) t_be[t_nwe] = ram_be;
            t_nwe++;
         end
         if (ram_re || ram_we) t_last = ram_addr;
         if (resp_valid) begin
            t_lat = k;
            t_rd  = resp_rdata;
            break;
         end
         @(negedge clk);
      end
   endtask

   typedef struct {
      string       name;
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rd;
      int          exp_lat;
      int          exp_re;
      int          exp_we;
      int          exp_last;
   } vec_t;

   vec_t vt[11];

   initial begin
      vt[0]  = '{"ld_aligned_8",   1'b0, 32'd8,          32'd0,          32'hDDCCBBAA, 3, 1, 0, 2};
      vt[1]  = '{"ld_off1_13",     1'b0, 32'd13,         32'd0,          32'h55443322, 4, 2, 0, 4};
      vt[2]  = '{"ld_off3_15",     1'b0, 32'd15,         32'd0,          32'h77665544, 4, 2, 0, 4};
      vt[3]  = '{"ld_off2_14",     1'b0, 32'd14,         32'd0,          32'h66554433, 4, 2, 0, 4};
      vt[4]  = '{"ld_wrap_4095",   1'b0, 32'd4095,       32'd0,          32'h223344AA, 4, 2, 0, 0};
      vt[5]  = '{"ld_alias_1008",  1'b0, 32'h0000_1008,  32'd0,          32'hDDCCBBAA, 3, 1, 0, 2};
      vt[6]  = '{"st_aligned_12",  1'b1, 32'd12,         32'h01020304,   32'd0,        2, 0, 1, 3};
      vt[7]  = '{"ld_aligned_12",  1'b0, 32'd12,         32'd0,          32'h01020304, 3, 1, 0, 3};
      vt[8]  = '{"st_debug",       1'b1, DBG,            32'h123456A5,   32'd0,        2, 0, 0, -1};
      vt[9]  = '{"ld_debug",       1'b0, DBG,            32'd0,          32'h000000A5, 2, 0, 0, -1};
      vt[10] = '{"ld_high_alias",  1'b0, 32'hFFFF_F010,  32'd0,          32'h88776655, 3, 1, 0, 4};

      rst = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;
      pl_en = 1'b0; pl_addr = '0; pl_data = 32'd0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_req_ready",  {31'b0, req_ready},  32'd1);
      chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
      chk("rst_resp_rdata", resp_rdata,          32'd0);
      chk("rst_ram_re_we",  {30'b0, ram_re, ram_we}, 32'd0);
      chk("rst_ram_be",     {28'b0, ram_be},     32'd0);
      chk("rst_ram_addr",   {22'b0, ram_addr},   32'd0);
      chk("rst_ram_wdata",  ram_wdata,           32'd0);
      chk("rst_debug_out",  {24'b0, debug_out},  32'h000000FF);

      preload(10'd2,    32'hDDCCBBAA);
      preload(10'd3,    32'h44332211);
      preload(10'd4,    32'h88776655);
      preload(10'd1023, 32'hAABBCCDD);
      preload(10'd0,    32'h11223344);
      rst = 1'b1;

      for (int i = 0; i < 11; i++) begin
         run(1'b0, vt[i].wr, vt[i].addr, vt[i].wdata);
         chk({vt[i].name, "_latency"}, 32'(t_lat), 32'(vt[i].exp_lat));
         chk({vt[i].name, "_re_count"}, 32'(t_nre), 32'(vt[i].exp_re));
         chk({vt[i].name, "_we_count"}, 32'(t_nwe), 32'(vt[i].exp_we));
         if (!vt[i].wr) chk({vt[i].name, "_rdata"}, t_rd, vt[i].exp_rd);
         if (vt[i].exp_last >= 0) chk({vt[i].name, "_last_ram_addr"}, {22'b0, t_last}, 32'(vt[i].exp_last));
         if (vt[i].wr && vt[i].addr == DBG) chk("debug_out_after_store", {24'b0, debug_out}, 32'h000000A5);
      end

      // Unaligned store straddling words 1 and 2
      preload(10'd1, 32'd0);
      preload(10'd2, 32'd0);
      run(1'b0, 1'b1, 32'd6, 32'hCAFEBABE);
      chk("st6_latency",  32'(t_lat), 32'd3);
      chk("st6_we_count", 32'(t_nwe), 32'd2);
      chk("st6_be_first", {28'b0, t_be[0]}, 32'h0000000C);
      chk("st6_be_second", {28'b0, t_be[1]}, 32'h00000003);
      @(negedge clk);
      chk("st6_word1", mem[1], 32'hBABE0000);
      chk("st6_word2", mem[2], 32'h0000CAFE);
      run(1'b0, 1'b0, 32'd6, 32'd0);
      chk("ld6_rdata", t_rd, 32'hCAFEBABE);

      // Back-to-back: next request issued in the response cycle
      run(1'b0, 1'b0, 32'd4, 32'd0);
      chk("b2b_first_rdata", t_rd, 32'hBABE0000);
      run(1'b1, 1'b0, 32'd12, 32'd0);
      chk("b2b_second_latency", 32'(t_lat), 32'd3);
      chk("b2b_second_rdata", t_rd, 32'h01020304);

      // Reset while the first word of an unaligned store is on the bus
      preload(10'd10, 32'h11111111);
      preload(10'd11, 32'h22222222);
      @(negedge clk);
      req_valid = 1'b1; req_write = 1'b1; req_addr = 32'd42; req_wdata = 32'hAABBCCDD;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      chk("midrst_first_we", {31'b0, ram_we}, 32'd1);
      rst = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      chk("midrst_req_ready",  {31'b0, req_ready},  32'd1);
      chk("midrst_ram_we",     {31'b0, ram_we},     32'd0);
      chk("midrst_resp_valid", {31'b0, resp_valid}, 32'd0);
      chk("midrst_debug_out",  {24'b0, debug_out},  32'h000000FF);
      begin
         int n_ev = 0;
         for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (resp_valid || ram_we) n_ev++;
         end
         chk("midrst_no_late_activity", 32'(n_ev), 32'd0);
      end
      chk("midrst_word11_unchanged", mem[11], 32'h22222222);
      run(1'b0, 1'b0, 32'd44, 32'd0);
      chk("midrst_followup_latency", 32'(t_lat), 32'd3);
      chk("midrst_followup_rdata", t_rd, 32'h22222222);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
`default_nettype wire
